// File: rtl/ahb_led_blink_pkg.sv
// rtl/ahb_led_blink_pkg.sv - register map, AHB encodings and state types for the LED blink controller
package ahb_led_blink_pkg;

  // Register byte offsets within the decoded window
  localparam logic [31:0] CTRL_OFS    = 32'h00;
  localparam logic [31:0] STATUS_OFS  = 32'h04;
  localparam logic [31:0] PERIOD_BASE = 32'h10;
  localparam logic [31:0] DUTY_BASE   = 32'h14;
  localparam logic [31:0] CH_STRIDE   = 32'h08;

  // Bit positions
  localparam int RESTART_BIT     = 31;
  localparam int STATUS_STOP_BIT = 16;

  // AHB encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Two-cycle ERROR response sequencer
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

  function automatic logic [31:0] period_ofs(input int n);
    return PERIOD_BASE + CH_STRIDE * 32'(n);
  endfunction

  function automatic logic [31:0] duty_ofs(input int n);
    return DUTY_BASE + CH_STRIDE * 32'(n);
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// rtl/led_blink_channel.sv - one period/duty blink channel: wrapping counter plus registered compare
//
// Ports:
//   sys_clock, resetn : clock, asynchronous active-low reset
//   enable            : channel enable; low holds cnt at 0 and drives led low
//   stop              : freeze cnt and led
//   clear             : force cnt to 0 this cycle, overriding stop and counting
//   period, duty      : blink period and on-time in clock cycles
//   led               : registered LED drive, active high
module led_blink_channel #(
  parameter int CNT_W = 32
) (
  input  logic             sys_clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             stop,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             led
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic             period_zero;
  logic             at_wrap;
  logic             led_next;

  always_comb begin
    period_zero = (period == '0);
    // >= rather than == so a counter already past a shrunken period still wraps
    at_wrap     = (cnt >= period - ONE);
    led_next    = enable & (period_zero ? (duty != '0) : (cnt < duty));
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      led <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (!stop) begin
        if (!enable || period_zero || at_wrap) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
      end
      if (!stop) begin
        led <= led_next;
      end
    end
  end

endmodule

// File: rtl/ahb_led_blink_ctrl.sv
// rtl/ahb_led_blink_ctrl.sv - AHB-Lite register bank driving NUM_LED period/duty blink channels
//
// Optional feature macro: AHB_LED_BLINK_CTRL_ERR_RESP_EN (two-cycle ERROR response for
// unmapped offsets and non-word writes; without it those complete OKAY with no effect).
//
// Ports:
//   sys_clock, resetn     : clock, asynchronous active-low reset
//   stop                  : freeze all channel counters; bus access unaffected
//   mem_ahb_hsel/hready/htrans/hwrite/haddr/hsize/hwdata : AHB-Lite slave inputs
//   mem_ahb_hreadyout/hresp/hrdata                       : AHB-Lite slave outputs
//   led                   : LED drive per channel, active high
module ahb_led_blink_ctrl
  import ahb_led_blink_pkg::*;
#(
  parameter int NUM_LED    = 2,
  parameter int CNT_W      = 32,
  parameter int ADDR_LSB_W = 8
) (
  input  logic               sys_clock,
  input  logic               resetn,
  input  logic               stop,
  input  logic               mem_ahb_hsel,
  input  logic               mem_ahb_hready,
  input  logic [1:0]         mem_ahb_htrans,
  input  logic               mem_ahb_hwrite,
  input  logic [31:0]        mem_ahb_haddr,
  input  logic [2:0]         mem_ahb_hsize,
  input  logic [31:0]        mem_ahb_hwdata,
  output logic               mem_ahb_hreadyout,
  output logic               mem_ahb_hresp,
  output logic [31:0]        mem_ahb_hrdata,
  output logic [NUM_LED-1:0] led
);

  logic                  accept;
  logic                  accept_ok;
  logic                  dp_valid;
  logic                  dp_write;
  logic                  dp_word;
  logic [ADDR_LSB_W-3:0] dp_addr;
  logic [31:0]           dp_off;
  logic                  commit;
  logic                  ctrl_we;
  logic                  restart;
  logic [NUM_LED-1:0]    period_we;
  logic [NUM_LED-1:0]    duty_we;
  logic [NUM_LED-1:0]    clear;
  logic [NUM_LED-1:0]    ctrl_en;
  logic [CNT_W-1:0]      period_q [NUM_LED];
  logic [CNT_W-1:0]      duty_q   [NUM_LED];
  logic [31:0]           rd_mux;

  // Address bits outside the decoded window and the htrans SEQ/NONSEQ distinction are don't-care
  logic unused_bits;
  assign unused_bits = &{1'b0, mem_ahb_haddr[31:ADDR_LSB_W], mem_ahb_haddr[1:0], mem_ahb_htrans[0]};

  assign accept = mem_ahb_hsel & mem_ahb_hready & mem_ahb_htrans[1];

`ifdef AHB_LED_BLINK_CTRL_ERR_RESP_EN
  logic [31:0] ap_off;
  logic        ap_mapped;
  logic        addr_err;
  err_state_e  err_state;
  err_state_e  err_next;

  always_comb begin
    ap_off = '0;
    ap_off[ADDR_LSB_W-1:0] = {mem_ahb_haddr[ADDR_LSB_W-1:2], 2'b00};
    ap_mapped = (ap_off == CTRL_OFS) || (ap_off == STATUS_OFS);
    for (int n = 0; n < NUM_LED; n++) begin
      if ((ap_off == period_ofs(n)) || (ap_off == duty_ofs(n))) begin
        ap_mapped = 1'b1;
      end
    end
    addr_err = !ap_mapped || (mem_ahb_hwrite && (mem_ahb_hsize != HSIZE_WORD));
  end

  // Errored transfers never reach the data-phase registers, so they cannot commit or read
  assign accept_ok = accept & ~addr_err;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      err_state <= ST_OKAY;
    end else begin
      err_state <= err_next;
    end
  end

  always_comb begin
    err_next          = err_state;
    mem_ahb_hreadyout = 1'b1;
    mem_ahb_hresp     = 1'b0;
    case (err_state)
      ST_OKAY: begin
        if (accept && addr_err) err_next = ST_ERR1;
      end
      ST_ERR1: begin
        mem_ahb_hreadyout = 1'b0;
        mem_ahb_hresp     = 1'b1;
        err_next          = ST_ERR2;
      end
      ST_ERR2: begin
        mem_ahb_hresp = 1'b1;
        err_next      = (accept && addr_err) ? ST_ERR1 : ST_OKAY;
      end
      default: err_next = ST_OKAY;
    endcase
  end
`else
  assign accept_ok         = accept;
  assign mem_ahb_hreadyout = 1'b1;
  assign mem_ahb_hresp     = 1'b0;
`endif

  // Address-phase capture; only advances when the bus completes the previous transfer
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      dp_addr  <= '0;
    end else if (mem_ahb_hready) begin
      dp_valid <= accept_ok;
      dp_write <= mem_ahb_hwrite;
      dp_word  <= (mem_ahb_hsize == HSIZE_WORD);
      dp_addr  <= mem_ahb_haddr[ADDR_LSB_W-1:2];
    end
  end

  assign commit = dp_valid & dp_write & dp_word;

  // Data-phase decode: read mux and write strobes share one offset compare
  always_comb begin
    dp_off = '0;
    dp_off[ADDR_LSB_W-1:0] = {dp_addr, 2'b00};
    rd_mux    = '0;
    ctrl_we   = 1'b0;
    period_we = '0;
    duty_we   = '0;
    if (dp_off == CTRL_OFS) begin
      rd_mux[NUM_LED-1:0] = ctrl_en;
      ctrl_we             = commit;
    end
    if (dp_off == STATUS_OFS) begin
      rd_mux[NUM_LED-1:0]     = led;
      rd_mux[STATUS_STOP_BIT] = stop;
    end
    for (int n = 0; n < NUM_LED; n++) begin
      if (dp_off == period_ofs(n)) begin
        rd_mux[CNT_W-1:0] = period_q[n];
        period_we[n]      = commit;
      end
      if (dp_off == duty_ofs(n)) begin
        rd_mux[CNT_W-1:0] = duty_q[n];
        duty_we[n]        = commit;
      end
    end
  end

  assign mem_ahb_hrdata = (dp_valid && !dp_write) ? rd_mux : '0;

  assign restart = ctrl_we & mem_ahb_hwdata[RESTART_BIT];
  assign clear   = {NUM_LED{restart}} | period_we;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      ctrl_en <= '0;
      for (int n = 0; n < NUM_LED; n++) begin
        period_q[n] <= '0;
        duty_q[n]   <= '0;
      end
    end else begin
      if (ctrl_we) ctrl_en <= mem_ahb_hwdata[NUM_LED-1:0];
      for (int n = 0; n < NUM_LED; n++) begin
        if (period_we[n]) period_q[n] <= mem_ahb_hwdata[CNT_W-1:0];
        if (duty_we[n])   duty_q[n]   <= mem_ahb_hwdata[CNT_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
    led_blink_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .sys_clock(sys_clock),
      .resetn   (resetn),
      .enable   (ctrl_en[g]),
      .stop     (stop),
      .clear    (clear[g]),
      .period   (period_q[g]),
      .duty     (duty_q[g]),
      .led      (led[g])
    );
  end

endmodule

// File: tb/tb_ahb_led_blink_ctrl.sv
// tb/tb_ahb_led_blink_ctrl.sv - scoreboard bench for ahb_led_blink_ctrl
module tb_ahb_led_blink_ctrl;

  localparam int NUM_LED = 2;
`ifdef AHB_LED_BLINK_CTRL_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               sys_clock = 1'b0;
  logic               resetn = 1'b0;
  logic               stop = 1'b0;
  logic               mem_ahb_hsel = 1'b0;
  logic               mem_ahb_hready;
  logic [1:0]         mem_ahb_htrans = 2'b00;
  logic               mem_ahb_hwrite = 1'b0;
  logic [31:0]        mem_ahb_haddr = '0;
  logic [2:0]         mem_ahb_hsize = 3'b010;
  logic [31:0]        mem_ahb_hwdata = '0;
  logic               mem_ahb_hreadyout;
  logic               mem_ahb_hresp;
  logic [31:0]        mem_ahb_hrdata;
  logic [NUM_LED-1:0] led;

  assign mem_ahb_hready = mem_ahb_hreadyout;

  always #5 sys_clock = ~sys_clock;

  ahb_led_blink_ctrl #(
    .NUM_LED   (NUM_LED),
    .CNT_W     (32),
    .ADDR_LSB_W(8)
  ) dut (
    .sys_clock        (sys_clock),
    .resetn           (resetn),
    .stop             (stop),
    .mem_ahb_hsel     (mem_ahb_hsel),
    .mem_ahb_hready   (mem_ahb_hready),
    .mem_ahb_htrans   (mem_ahb_htrans),
    .mem_ahb_hwrite   (mem_ahb_hwrite),
    .mem_ahb_haddr    (mem_ahb_haddr),
    .mem_ahb_hsize    (mem_ahb_hsize),
    .mem_ahb_hwdata   (mem_ahb_hwdata),
    .mem_ahb_hreadyout(mem_ahb_hreadyout),
    .mem_ahb_hresp    (mem_ahb_hresp),
    .mem_ahb_hrdata   (mem_ahb_hrdata),
    .led              (led)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    string       name;
  } exp_t;

  exp_t        rd_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        dp_rd = 1'b0;
  logic [31:0] pend_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One address phase; write data for the previous address phase rides along
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, input logic [31:0] exp_rd, input logic exp_resp,
                      input string name);
    exp_t e;
    mem_ahb_hsel   = 1'b1;
    mem_ahb_htrans = 2'b10;
    mem_ahb_hwrite = wr;
    mem_ahb_haddr  = addr;
    mem_ahb_hsize  = size;
    mem_ahb_hwdata = pend_wdata;
    if (!wr) begin
      e.rdata = exp_rd;
      e.resp  = exp_resp;
      e.name  = name;
      rd_q.push_back(e);
    end
    @(posedge sys_clock);
    #1;
    pend_wdata = wdata;
  endtask

  task automatic wr_w(input logic [31:0] addr, input logic [31:0] data);
    xfer(1'b1, addr, data, 3'b010, 32'h0, 1'b0, "");
  endtask

  task automatic rd_w(input logic [31:0] addr, input logic [31:0] exp, input string name);
    xfer(1'b0, addr, 32'h0, 3'b010, exp, 1'b0, name);
  endtask

  task automatic idle();
    mem_ahb_hsel   = 1'b0;
    mem_ahb_htrans = 2'b00;
    mem_ahb_hwrite = 1'b0;
    mem_ahb_hwdata = pend_wdata;
    @(posedge sys_clock);
    #1;
  endtask

  task automatic hold(input int idx, input logic exp, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clock);
      @(negedge sys_clock);
      chk(name, 32'(led[idx]), 32'(exp));
    end
  endtask

  // Monitor: follow the bus into each read data phase and score it when the slave completes
  always @(posedge sys_clock) begin
    if (mem_ahb_hready) dp_rd <= mem_ahb_hsel & mem_ahb_htrans[1] & ~mem_ahb_hwrite;
  end

  always @(negedge sys_clock) begin
    if (dp_rd && mem_ahb_hreadyout) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", mem_ahb_hrdata);
      end else begin
        mon_e = rd_q.pop_front();
        chk({mon_e.name, " hrdata"}, mem_ahb_hrdata, mon_e.rdata);
        chk({mon_e.name, " hresp"}, 32'(mem_ahb_hresp), 32'(mon_e.resp));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    resetn = 1'b1;
    chk("reset hreadyout", 32'(mem_ahb_hreadyout), 32'h1);
    chk("reset hresp", 32'(mem_ahb_hresp), 32'h0);
    chk("reset led", 32'(led), 32'h0);
    chk("reset hrdata", mem_ahb_hrdata, 32'h0);
    rd_w(32'h00, 32'h0, "reset ctrl");
    rd_w(32'h04, 32'h0, "reset status");
    rd_w(32'h10, 32'h0, "reset period0");
    rd_w(32'h14, 32'h0, "reset duty0");
    idle();

    // Blink: period 4, duty 1 -> 1,0,0,0 starting one cycle after the CTRL commit
    wr_w(32'h10, 32'd4);
    wr_w(32'h14, 32'd1);
    wr_w(32'h00, 32'h1);
    idle();
    @(negedge sys_clock);
    chk("blink before first high", 32'(led[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clock);
      @(negedge sys_clock);
      chk($sformatf("blink step %0d", i), 32'(led[0]), 32'(i % 4 == 0));
    end

    // Stop with cnt=0, led=0: next edge would raise led, so it must stay low while frozen
    stop = 1'b1;
    rd_w(32'h04, 32'h0001_0000, "status while stopped");
    idle();
    rd_w(32'h10, 32'd4, "period0 while stopped");
    idle();
    repeat (6) begin
      @(negedge sys_clock);
      chk("led frozen", 32'(led[0]), 32'h0);
      @(posedge sys_clock);
    end
    @(negedge sys_clock);
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clock);
      @(negedge sys_clock);
      chk($sformatf("resume step %0d", i), 32'(led[0]), 32'(i == 0));
    end

    // cnt is now 2; restart under stop must clear it so release gives a high immediately
    stop = 1'b1;
    wr_w(32'h00, 32'h8000_0003);
    idle();
    rd_w(32'h00, 32'h3, "ctrl after restart");
    idle();
    @(negedge sys_clock);
    chk("led held under restart", 32'(led[0]), 32'h0);
    stop = 1'b0;
    @(posedge sys_clock);
    @(negedge sys_clock);
    chk("restart first high", 32'(led[0]), 32'h1);
    chk("ch1 period0 duty0 off", 32'(led[1]), 32'h0);
    @(posedge sys_clock);
    @(negedge sys_clock);
    chk("restart second low", 32'(led[0]), 32'h0);

    // Channel 1 boundaries
    wr_w(32'h18, 32'd0);
    wr_w(32'h1C, 32'd5);
    idle();
    hold(1, 1'b1, 3, "period0 duty5 on");
    wr_w(32'h1C, 32'd0);
    idle();
    hold(1, 1'b0, 3, "duty0 off");
    wr_w(32'h18, 32'd3);
    wr_w(32'h1C, 32'd7);
    idle();
    hold(1, 1'b1, 4, "duty above period on");

    // Bus timing
    wr_w(32'h10, 32'h20);
    rd_w(32'h10, 32'h20, "back-to-back read");
    idle();
    xfer(1'b1, 32'h10, 32'h55, 3'b000, 32'h0, 1'b0, "");
    idle();
    idle();
    rd_w(32'h10, 32'h20, "byte write ignored");
    idle();

    // Unmapped read
    xfer(1'b0, 32'h80, 32'h0, 3'b010, 32'h0, ERR_EN, "unmapped read");
    @(negedge sys_clock);
    chk("unmapped cycle1 hreadyout", 32'(mem_ahb_hreadyout), 32'(!ERR_EN));
    chk("unmapped cycle1 hresp", 32'(mem_ahb_hresp), 32'(ERR_EN));
    idle();
    @(negedge sys_clock);
    chk("unmapped cycle2 hreadyout", 32'(mem_ahb_hreadyout), 32'h1);
    chk("unmapped cycle2 hresp", 32'(mem_ahb_hresp), 32'(ERR_EN));
    idle();

    // Asynchronous reset mid-operation (led[1] is constant on here)
    @(negedge sys_clock);
    resetn = 1'b0;
    #1;
    chk("async reset led", 32'(led), 32'h0);
    @(negedge sys_clock);
    resetn = 1'b1;
    rd_w(32'h00, 32'h0, "ctrl after mid reset");
    rd_w(32'h1C, 32'h0, "duty1 after mid reset");
    idle();
    @(negedge sys_clock);
    chk("led after mid reset", 32'(led), 32'h0);

    repeat (2) @(negedge sys_clock);
    chk("scoreboard drained", 32'(rd_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_led_blink_ctrl.md
Name: ahb_led_blink_ctrl

Overview:
- AHB-Lite slave register bank that configures and sequences the board LED outputs (LED_D2/LED_D3) from the RISC-V core's mem_ahb port.
- Each LED channel runs an independent period/duty blink counter in the sys_clock domain.
- Channels freeze while the core's stop signal is asserted.
- Instantiated inside the user-logic macro, between the mem_ahb bus and the LED pins.

Parameters:
- NUM_LED, 2, number of blink channels (1..8)
- CNT_W, 32, width of PERIOD/DUTY registers and channel counters
- ADDR_LSB_W, 8, number of low haddr bits decoded; upper bits ignored

Ports:
- sys_clock  in  1  system clock (sys_gck)
- resetn  in  1  asynchronous active-low reset
- stop  in  1  high = freeze all channel counters; register access unaffected
- mem_ahb_hsel  in  1  slave select
- mem_ahb_hready  in  1  bus ready (previous transfer complete)
- mem_ahb_htrans  in  2  transfer type; bit1 = NONSEQ/SEQ
- mem_ahb_hwrite  in  1  1 = write
- mem_ahb_haddr  in  32  address
- mem_ahb_hsize  in  3  transfer size; only 3'b010 (word) writes take effect
- mem_ahb_hwdata  in  32  write data (data phase)
- mem_ahb_hreadyout  out  1  slave ready
- mem_ahb_hresp  out  1  0 = OKAY, 1 = ERROR
- mem_ahb_hrdata  out  32  read data (data phase)
- led  out  NUM_LED  LED drive, active high

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bits[NUM_LED-1:0] channel enable, RW. Bit 31 RESTART: write-1 pulse, reads 0.
  - 0x04 STATUS: RO. bits[NUM_LED-1:0] current led; bit 16 = stop.
  - 0x10+8n PERIODn, RW.
  - 0x14+8n DUTYn, RW.
  - Unmapped addresses read 0 and ignore writes.
- Reset values:
  - CTRL 0; PERIODn 0; DUTYn 0; counters 0.
  - led 0; hreadyout 1; hresp 0; hrdata 0.
- AHB handshake:
  - Address phase is accepted when hsel & hready & htrans[1].
  - Registered in the phase: hwrite, haddr[ADDR_LSB_W-1:2], and hsize==word.
  - Zero wait states: hreadyout stays 1 and hresp stays 0 unless the optional feature is enabled.
  - Write data is committed at the end of the data phase (the cycle after acceptance).
  - Read data is driven combinationally during the data phase from the registered address. The value is sampled at the data phase, so a write immediately preceding it is visible.
  - Back-to-back transfers are supported every cycle.
  - IDLE/BUSY transfers are ignored.
- Channel n:
  - Counter cnt counts 0..PERIODn-1 and wraps to 0.
  - led[n] = enable & (cnt < DUTYn).
  - DUTYn >= PERIODn gives a constant on; DUTYn == 0 gives a constant off.
  - PERIODn == 0: cnt held at 0, and led[n] = enable & (DUTYn != 0).
  - Enable low: cnt held at 0, led[n] = 0.
  - led is registered: it reflects cnt one cycle later.
  - stop high: cnt and led hold their values.
- Restart and write events:
  - A RESTART write or any write to PERIODn clears the affected counters to 0 on the commit cycle. This takes priority over increment, wrap, and stop.
  - RESTART clears all channels.
  - A write to DUTYn does not reset the counter.
- Reset mid-operation: all state returns to reset values asynchronously. The first access after resetn deasserts is accepted normally.

Optional Feature:
- Macro: AHB_LED_BLINK_CTRL_ERR_RESP_EN.
- Defined:
  - Accesses to unmapped offsets, and non-word writes, get the standard two-cycle ERROR response.
  - Cycle 1: hreadyout=0, hresp=1. Cycle 2: hreadyout=1, hresp=1.
  - No register changes.
  - A transfer presented during cycle 1 is not accepted, because hready is low.
- Undefined: such accesses complete with OKAY and have no effect (reads return 0).

Decomposition:
- Package ahb_led_blink_pkg holds:
  - register offset constants: CTRL, STATUS, PERIOD_BASE, DUTY_BASE, CH_STRIDE
  - RESTART bit index
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ encodings
  - HSIZE_WORD
- Sub-module led_blink_channel: one per LED, generated NUM_LED times.
  - Inputs: enable, stop, clear, period, duty.
  - Output: led.
  - Contains the counter and the compare.
- Top level holds: AHB decode, data-phase registers, register file, and the optional error FSM (OKAY / ERR1 / ERR2).

Test Plan:
- Reset defaults: after reset, read 0x00/0x04/0x10/0x14 -> all 0; hreadyout=1, hresp=0, led=0.
- Blink timing: write PERIOD0=4, DUTY0=1, CTRL=0x1 -> led[0] pattern 1,0,0,0 repeating. The first high appears 1 cycle after the CTRL commit.
- Boundaries: PERIOD1=0 with DUTY1=5 -> led[1] constant 1 when enabled. DUTY1=0 -> constant 0. PERIOD1=3 with DUTY1=7 -> constant 1.
- Stop and restart:
  - Assert stop for 10 cycles mid-period -> led and counters frozen, register reads still valid.
  - Writing CTRL=0x8000_0003 while stop is high -> counters 0; CTRL reads 0x3.
- Bus timing:
  - Back-to-back write 0x10=0x20 then read 0x10 -> hrdata=0x20 in the next data phase.
  - Byte write (hsize=0) to 0x10 -> value unchanged.
- Error response (macro defined): read 0x80 -> hreadyout 0 then 1, with hresp=1 both cycles. Without the macro -> OKAY, hrdata=0.
